// File: rtl/coeff_unpacker_if.sv
// coeff_unpacker_if
// Groups the two streaming handshakes of the coefficient unpacker: the packed
// word stream coming from the operand BRAM read port and the coefficient
// stream going to the multiplier.
// Signals:
//   word_in     [WORD_W]   packed data word
//   word_valid             word_in valid
//   word_ready             unpacker accepts word_in this cycle
//   coeff_out   [COEFF_W]  current coefficient
//   coeff_valid            coeff_out valid
//   coeff_ready            downstream accepts coeff_out
// Modports:
//   master  the surrounding system (drives words, consumes coefficients)
//   slave   the unpacker itself
interface coeff_unpacker_if #(
    parameter int WORD_W  = 64,
    parameter int COEFF_W = 13
) ();
    logic [WORD_W-1:0]  word_in;
    logic               word_valid;
    logic               word_ready;
    logic [COEFF_W-1:0] coeff_out;
    logic               coeff_valid;
    logic               coeff_ready;

    modport master (
        output word_in,
        output word_valid,
        input  word_ready,
        input  coeff_out,
        input  coeff_valid,
        output coeff_ready
    );

    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready,
        output coeff_out,
        output coeff_valid,
        input  coeff_ready
    );
endinterface

// File: rtl/coeff_unpacker.sv
// coeff_unpacker
// Streaming unpacker for the Saber polynomial multiplier. Packed polynomial
// data arrives as WORD_W-bit memory words (word 0 first, LSB first) and leaves
// as one coefficient per handshake in index order, either COEFF_W bits wide
// (full mode) or SHORT_W bits wide (short mode, widened to COEFF_W).
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          one-cycle pulse that begins a polynomial (honoured in IDLE only)
//   ten_bit_coeff  mode, sampled on start: 1 = SHORT_W-bit, 0 = COEFF_W-bit
//   bus            coeff_unpacker_if.slave (word stream in, coefficient stream out)
//   busy           polynomial in progress
//   done           one-cycle pulse after the last coefficient handshake
// Build option:
//   COEFF_UNPACKER_SEXT_EN  defined: short-mode coefficients are sign-extended
//                           from bit SHORT_W-1; undefined: zero-extended.
module coeff_unpacker #(
    parameter int WORD_W  = 64,
    parameter int COEFF_W = 13,
    parameter int SHORT_W = 10,
    parameter int N_COEFF = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            ten_bit_coeff,
    coeff_unpacker_if.slave bus,
    output logic            busy,
    output logic            done
);
    localparam int BUF_W       = 2 * WORD_W;
    // One spare bit so fill + WORD_W never wraps before the comparison.
    localparam int FILL_W      = $clog2(BUF_W + 1) + 1;
    localparam int WORDS_FULL  = (N_COEFF * COEFF_W + WORD_W - 1) / WORD_W;
    localparam int WORDS_SHORT = (N_COEFF * SHORT_W + WORD_W - 1) / WORD_W;
    localparam int WCNT_W      = $clog2(WORDS_FULL + 1);
    localparam int CCNT_W      = $clog2(N_COEFF + 1);

    localparam logic [FILL_W-1:0] WORD_W_F      = FILL_W'(WORD_W);
    localparam logic [FILL_W-1:0] BUF_W_F       = FILL_W'(BUF_W);
    localparam logic [FILL_W-1:0] COEFF_W_F     = FILL_W'(COEFF_W);
    localparam logic [FILL_W-1:0] SHORT_W_F     = FILL_W'(SHORT_W);
    localparam logic [WCNT_W-1:0] WORDS_FULL_C  = WCNT_W'(WORDS_FULL);
    localparam logic [WCNT_W-1:0] WORDS_SHORT_C = WCNT_W'(WORDS_SHORT);
    localparam logic [CCNT_W-1:0] N_COEFF_C     = CCNT_W'(N_COEFF);
    localparam logic [CCNT_W-1:0] ONE_LEFT      = CCNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic              short_mode_q, short_mode_d;
    logic [BUF_W-1:0]  data_buf_q, data_buf_d;
    logic [BUF_W-1:0]  shifted;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [FILL_W-1:0] fill_after;
    logic [FILL_W-1:0] coeff_width;
    logic [WCNT_W-1:0] words_left_q, words_left_d;
    logic [CCNT_W-1:0] coeffs_left_q, coeffs_left_d;
    logic              coeff_valid;
    logic              coeff_fire;
    logic              word_ready;
    logic              word_fire;
    logic [COEFF_W-1:0] coeff_out;

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign coeff_width = short_mode_q ? SHORT_W_F : COEFF_W_F;

    assign coeff_valid = (state_q == RUN) && (fill_q >= coeff_width) && (coeffs_left_q != '0);
    assign coeff_fire  = coeff_valid && bus.coeff_ready;

    // Room for a new word is judged after a same-cycle shift, so a word can be
    // taken every cycle a coefficient leaves even when the buffer looks tight.
    assign fill_after  = coeff_fire ? (fill_q - coeff_width) : fill_q;
    assign word_ready  = busy && (words_left_q != '0) && ((fill_after + WORD_W_F) <= BUF_W_F);
    assign word_fire   = word_ready && bus.word_valid;

    assign bus.coeff_valid = coeff_valid;
    assign bus.word_ready  = word_ready;
    assign bus.coeff_out   = coeff_out;

    // Low bits of the buffer are always the next coefficient.
    always_comb begin
        coeff_out = data_buf_q[COEFF_W-1:0];
        if (short_mode_q) begin
`ifdef COEFF_UNPACKER_SEXT_EN
            coeff_out = {{(COEFF_W - SHORT_W){data_buf_q[SHORT_W-1]}}, data_buf_q[SHORT_W-1:0]};
`else
            coeff_out = {{(COEFF_W - SHORT_W){1'b0}}, data_buf_q[SHORT_W-1:0]};
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update. Bits at or above fill are kept zero, so a
    // new word can simply be OR-ed in at the (post-shift) fill position.
    always_comb begin
        state_d       = state_q;
        short_mode_d  = short_mode_q;
        data_buf_d    = data_buf_q;
        fill_d        = fill_q;
        words_left_d  = words_left_q;
        coeffs_left_d = coeffs_left_q;
        shifted       = data_buf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = RUN;
                    short_mode_d  = ten_bit_coeff;
                    data_buf_d    = '0;
                    fill_d        = '0;
                    words_left_d  = ten_bit_coeff ? WORDS_SHORT_C : WORDS_FULL_C;
                    coeffs_left_d = N_COEFF_C;
                end
            end
            RUN: begin
                if (coeff_fire) begin
                    shifted = data_buf_q >> coeff_width;
                end
                data_buf_d = shifted;
                fill_d     = fill_after;
                if (word_fire) begin
                    data_buf_d   = shifted | (BUF_W'(bus.word_in) << fill_after);
                    fill_d       = fill_after + WORD_W_F;
                    words_left_d = words_left_q - 1'b1;
                end
                if (coeff_fire) begin
                    coeffs_left_d = coeffs_left_q - 1'b1;
                    if (coeffs_left_q == ONE_LEFT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Drop any trailing pad bits of the last word.
                state_d    = IDLE;
                data_buf_d = '0;
                fill_d     = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            short_mode_q  <= 1'b0;
            data_buf_q    <= '0;
            fill_q        <= '0;
            words_left_q  <= '0;
            coeffs_left_q <= '0;
        end else begin
            short_mode_q  <= short_mode_d;
            data_buf_q    <= data_buf_d;
            fill_q        <= fill_d;
            words_left_q  <= words_left_d;
            coeffs_left_q <= coeffs_left_d;
        end
    end
endmodule

// File: tb/tb_coeff_unpacker.sv
// tb_coeff_unpacker
// Self-checking bench for coeff_unpacker. Coefficient lists are packed into a
// bit stream by plain index arithmetic and the unpacked output is compared
// against the original list; buffer occupancy is tracked from handshake counts.
module tb_coeff_unpacker;
    localparam int WORD_W  = 64;
    localparam int COEFF_W = 13;
    localparam int SHORT_W = 10;
    localparam int N_COEFF = 256;

    logic clk;
    logic rst_n;
    logic start;
    logic ten_bit_coeff;
    logic busy;
    logic done;

    coeff_unpacker_if #(.WORD_W(WORD_W), .COEFF_W(COEFF_W)) bus ();

    coeff_unpacker #(
        .WORD_W (WORD_W),
        .COEFF_W(COEFF_W),
        .SHORT_W(SHORT_W),
        .N_COEFF(N_COEFF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .ten_bit_coeff(ten_bit_coeff),
        .bus          (bus),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    logic [WORD_W-1:0]  words_mem [0:63];
    int                 n_words;
    logic [COEFF_W-1:0] src_coeff [0:N_COEFF-1];
    logic [COEFF_W-1:0] exp_q [$];
    logic [COEFF_W-1:0] got_q [$];

    int   word_hs, first_w_cyc, last_c_cyc, done_cyc, done_cnt;
    int   proto_err, stall_err, fill_err;
    logic busy_at_done, busy_after_done;
    bit   timed_out;

    function automatic logic [COEFF_W-1:0] extend_short(input logic [SHORT_W-1:0] v);
`ifdef COEFF_UNPACKER_SEXT_EN
        return {{(COEFF_W - SHORT_W){v[SHORT_W-1]}}, v};
`else
        return {{(COEFF_W - SHORT_W){1'b0}}, v};
`endif
    endfunction

    // Coefficient i goes to stream bits [i*w +: w]; stream bit p is bit p%64 of word p/64.
    task automatic pack_stream(input int w);
        n_words = (N_COEFF * w + WORD_W - 1) / WORD_W;
        for (int k = 0; k < 64; k++) words_mem[k] = '0;
        for (int i = 0; i < N_COEFF; i++) begin
            for (int b = 0; b < w; b++) begin
                int pos;
                pos = i * w + b;
                words_mem[pos / WORD_W][pos % WORD_W] = src_coeff[i][b];
            end
        end
    endtask

    task automatic make_ramp();
        exp_q.delete();
        for (int i = 0; i < N_COEFF; i++) begin
            src_coeff[i] = COEFF_W'(i);
            exp_q.push_back(COEFF_W'(i));
        end
        pack_stream(COEFF_W);
    endtask

    task automatic make_random_short();
        logic [SHORT_W-1:0] v;
        exp_q.delete();
        for (int i = 0; i < N_COEFF; i++) begin
            v = SHORT_W'($urandom_range(0, (1 << SHORT_W) - 1));
            src_coeff[i] = COEFF_W'(v);
            exp_q.push_back(extend_short(v));
        end
        pack_stream(SHORT_W);
    endtask

    // Starts a polynomial and runs both streams until two cycles after done,
    // a reset abort after abort_after coefficients, or the cycle budget.
    task automatic stream_poly(input bit short_mode, input int word_pct, input int ready_pct,
                               input int abort_after, input bit spam);
        int w, wacc, cacc, cyc, model_fill, done_at;
        bit exp_cv, exp_wr, cfire, wfire, prev_stall, final_prev, fin;
        logic [COEFF_W-1:0] prev_out;
        w = short_mode ? SHORT_W : COEFF_W;
        got_q.delete();
        word_hs = 0; first_w_cyc = -1; last_c_cyc = -1; done_cyc = -1; done_cnt = 0;
        proto_err = 0; stall_err = 0; fill_err = 0;
        busy_at_done = 1'bx; busy_after_done = 1'bx; timed_out = 0;
        wacc = 0; cacc = 0; cyc = 0; done_at = -1;
        prev_stall = 0; final_prev = 0; fin = 0; prev_out = '0;

        @(posedge clk); #1;
        start = 1'b1; ten_bit_coeff = short_mode;
        bus.word_valid = 1'b0; bus.coeff_ready = 1'b0;
        @(posedge clk); #1;
        while (!fin) begin
            start = 1'b0; ten_bit_coeff = short_mode;
            if (spam && (final_prev || (cacc < N_COEFF && $urandom_range(0, 99) < 8))) begin
                start = 1'b1; ten_bit_coeff = !short_mode;
            end
            bus.word_valid  = (wacc < n_words) && ($urandom_range(0, 99) < word_pct);
            bus.word_in     = bus.word_valid ? words_mem[wacc] : {$urandom, $urandom};
            bus.coeff_ready = ($urandom_range(0, 99) < ready_pct);
            @(negedge clk);

            model_fill = wacc * WORD_W - cacc * w;
            exp_cv = (model_fill >= w) && (cacc < N_COEFF);
            exp_wr = (wacc < n_words) &&
                     ((model_fill - ((exp_cv && bus.coeff_ready) ? w : 0) + WORD_W) <= 2 * WORD_W);
            if (bus.coeff_valid !== exp_cv || bus.word_ready !== exp_wr) proto_err++;
            if (model_fill > 2 * WORD_W || model_fill < 0) fill_err++;
            if (bus.word_ready === 1'b1 &&
                (model_fill - ((bus.coeff_valid && bus.coeff_ready) ? w : 0) + WORD_W) > 2 * WORD_W)
                fill_err++;
            if (prev_stall && (bus.coeff_valid !== 1'b1 || bus.coeff_out !== prev_out)) stall_err++;

            cfire = (bus.coeff_valid === 1'b1) && bus.coeff_ready;
            wfire = (bus.word_ready === 1'b1) && bus.word_valid;
            prev_stall = (bus.coeff_valid === 1'b1) && !bus.coeff_ready;
            prev_out = bus.coeff_out;
            if (wfire) begin
                if (first_w_cyc < 0) first_w_cyc = cyc;
                wacc++;
            end
            if (cfire) begin
                got_q.push_back(bus.coeff_out);
                cacc++;
                last_c_cyc = cyc;
            end
            word_hs = wacc;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = cyc;
                    busy_at_done = busy;
                end
            end
            if (done_at >= 0 && cyc == done_at + 1) busy_after_done = busy;
            final_prev = cfire && (cacc == N_COEFF);

            if (abort_after > 0 && cacc >= abort_after) begin
                #2;
                rst_n = 1'b0;
                fin = 1;
            end else if (done_at >= 0 && cyc >= done_at + 2) begin
                fin = 1;
            end else if (cyc >= 4000) begin
                timed_out = 1;
                fin = 1;
            end
            cyc++;
            if (!fin) begin
                @(posedge clk); #1;
            end
        end
        done_cyc = done_at;
        start = 1'b0;
        bus.word_valid = 1'b0;
        bus.coeff_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; ten_bit_coeff = 1'b0;
        bus.word_valid = 1'b0; bus.word_in = '0; bus.coeff_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        total++; if (bus.coeff_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_coeff_valid: got %b expected 0", bus.coeff_valid); end
        total++; if (bus.word_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_word_ready: got %b expected 0", bus.word_ready); end
        total++; if (bus.coeff_out !== '0) begin bad++; $display("[TB] FAIL reset_coeff_out: got %h expected 0", bus.coeff_out); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_ramp_full();
        make_ramp();
        stream_poly(1'b0, 100, 100, 0, 1'b0);
        total++; if (timed_out) begin bad++; $display("[TB] FAIL full_timeout: got timeout expected done"); end
        total++; if (word_hs != 52) begin bad++; $display("[TB] FAIL full_words: got %0d expected 52", word_hs); end
        total++; if (got_q.size() != N_COEFF) begin bad++; $display("[TB] FAIL full_count: got %0d expected %0d", got_q.size(), N_COEFF); end
        for (int i = 0; i < got_q.size() && i < N_COEFF; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL full_seq[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL full_done_count: got %0d expected 1", done_cnt); end
        total++; if (done_cyc != last_c_cyc + 1) begin bad++; $display("[TB] FAIL full_done_timing: got %0d expected %0d", done_cyc, last_c_cyc + 1); end
        total++; if (busy_at_done !== 1'b1) begin bad++; $display("[TB] FAIL full_busy_at_done: got %b expected 1", busy_at_done); end
        total++; if (busy_after_done !== 1'b0) begin bad++; $display("[TB] FAIL full_busy_after_done: got %b expected 0", busy_after_done); end
        total++; if (proto_err != 0) begin bad++; $display("[TB] FAIL full_handshake: got %0d errors expected 0", proto_err); end
        total++;
        if (first_w_cyc < 0 || (last_c_cyc - first_w_cyc) > 258) begin
            bad++; $display("[TB] FAIL full_rate: got %0d cycles expected <= 258", last_c_cyc - first_w_cyc);
        end
    endtask

    task automatic test_short_ones();
        logic [COEFF_W-1:0] ones_exp;
        ones_exp = extend_short({SHORT_W{1'b1}});
        for (int k = 0; k < 64; k++) words_mem[k] = '1;
        n_words = 40;
        stream_poly(1'b1, 70, 80, 0, 1'b0);
        total++; if (timed_out) begin bad++; $display("[TB] FAIL ones_timeout: got timeout expected done"); end
        total++; if (word_hs != 40) begin bad++; $display("[TB] FAIL ones_words: got %0d expected 40", word_hs); end
        total++; if (got_q.size() != N_COEFF) begin bad++; $display("[TB] FAIL ones_count: got %0d expected %0d", got_q.size(), N_COEFF); end
        for (int i = 0; i < got_q.size() && i < N_COEFF; i++) begin
            total++;
            if (got_q[i] !== ones_exp) begin bad++; $display("[TB] FAIL ones_seq[%0d]: got %h expected %h", i, got_q[i], ones_exp); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL ones_done_count: got %0d expected 1", done_cnt); end
        total++; if (proto_err != 0) begin bad++; $display("[TB] FAIL ones_handshake: got %0d errors expected 0", proto_err); end
    endtask

    task automatic test_backpressure();
        make_ramp();
        stream_poly(1'b0, 60, 50, 0, 1'b0);
        total++; if (timed_out) begin bad++; $display("[TB] FAIL bp_timeout: got timeout expected done"); end
        total++; if (got_q.size() != N_COEFF) begin bad++; $display("[TB] FAIL bp_count: got %0d expected %0d", got_q.size(), N_COEFF); end
        for (int i = 0; i < got_q.size() && i < N_COEFF; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL bp_seq[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (stall_err != 0) begin bad++; $display("[TB] FAIL bp_stall_stable: got %0d changes expected 0", stall_err); end
        total++; if (fill_err != 0) begin bad++; $display("[TB] FAIL bp_fill_bound: got %0d overflows expected 0", fill_err); end
        total++; if (proto_err != 0) begin bad++; $display("[TB] FAIL bp_handshake: got %0d errors expected 0", proto_err); end
        total++; if (word_hs != 52) begin bad++; $display("[TB] FAIL bp_words: got %0d expected 52", word_hs); end
    endtask

    task automatic test_random_short();
        make_random_short();
        stream_poly(1'b1, 75, 60, 0, 1'b0);
        total++; if (timed_out) begin bad++; $display("[TB] FAIL rs_timeout: got timeout expected done"); end
        total++; if (got_q.size() != N_COEFF) begin bad++; $display("[TB] FAIL rs_count: got %0d expected %0d", got_q.size(), N_COEFF); end
        for (int i = 0; i < got_q.size() && i < N_COEFF; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL rs_seq[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (stall_err != 0) begin bad++; $display("[TB] FAIL rs_stall_stable: got %0d changes expected 0", stall_err); end
        total++; if (proto_err != 0) begin bad++; $display("[TB] FAIL rs_handshake: got %0d errors expected 0", proto_err); end
    endtask

    task automatic test_start_ignored();
        make_ramp();
        stream_poly(1'b0, 90, 70, 0, 1'b1);
        total++; if (timed_out) begin bad++; $display("[TB] FAIL si_timeout: got timeout expected done"); end
        total++; if (word_hs != 52) begin bad++; $display("[TB] FAIL si_words: got %0d expected 52", word_hs); end
        total++; if (got_q.size() != N_COEFF) begin bad++; $display("[TB] FAIL si_count: got %0d expected %0d", got_q.size(), N_COEFF); end
        for (int i = 0; i < got_q.size() && i < N_COEFF; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL si_seq[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL si_done_count: got %0d expected 1", done_cnt); end
        total++; if (busy_after_done !== 1'b0) begin bad++; $display("[TB] FAIL si_busy_after_done: got %b expected 0", busy_after_done); end

        // Fresh start in IDLE with the opposite mode.
        make_random_short();
        stream_poly(1'b1, 80, 80, 0, 1'b0);
        total++; if (word_hs != 40) begin bad++; $display("[TB] FAIL fresh_words: got %0d expected 40", word_hs); end
        total++; if (got_q.size() != N_COEFF) begin bad++; $display("[TB] FAIL fresh_count: got %0d expected %0d", got_q.size(), N_COEFF); end
        for (int i = 0; i < got_q.size() && i < N_COEFF; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL fresh_seq[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_abort();
        int dcount;
        make_ramp();
        stream_poly(1'b0, 80, 60, 100, 1'b0);
        #1;
        total++; if (bus.coeff_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_coeff_valid: got %b expected 0", bus.coeff_valid); end
        total++; if (bus.word_ready !== 1'b0) begin bad++; $display("[TB] FAIL abort_word_ready: got %b expected 0", bus.word_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
        total++; if (bus.coeff_out !== '0) begin bad++; $display("[TB] FAIL abort_coeff_out: got %h expected 0", bus.coeff_out); end
        total++; if (got_q.size() != 100) begin bad++; $display("[TB] FAIL abort_partial_count: got %0d expected 100", got_q.size()); end
        dcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) dcount++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (done !== 1'b0) dcount++;
        total++; if (dcount != 0) begin bad++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", dcount); end

        stream_poly(1'b0, 100, 100, 0, 1'b0);
        total++; if (got_q.size() != N_COEFF) begin bad++; $display("[TB] FAIL rerun_count: got %0d expected %0d", got_q.size(), N_COEFF); end
        for (int i = 0; i < got_q.size() && i < N_COEFF; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL rerun_seq[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL rerun_done_count: got %0d expected 1", done_cnt); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_ramp_full();
        test_short_ones();
        test_backpressure();
        test_random_short();
        test_start_ignored();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/coeff_unpacker.md
# coeff_unpacker

- Streaming unpacker for the Saber polynomial multiplier.
- Accepts packed polynomial data as fixed-width memory words and emits one coefficient per handshake in index order.
- Two modes: full-width (13-bit) and short (10-bit) coefficients.
- Parametrised, sequential successor to the combinational coefficient selector.
  - Owns its own bit buffer, fill tracking, word fetch handshake and end-of-polynomial detection.
- Sits between the operand BRAM read port and the multiplier's coefficient input.

## Interface
Parameters:
- WORD_W, 64, width of input memory word; must satisfy WORD_W >= COEFF_W
- COEFF_W, 13, full-mode coefficient width and output width
- SHORT_W, 10, short-mode coefficient width; SHORT_W < COEFF_W
- N_COEFF, 256, coefficients per polynomial

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins a polynomial
- ten_bit_coeff  in  1  mode, sampled on start: 1 = SHORT_W-bit, 0 = COEFF_W-bit
- word_in  in  WORD_W  packed data word
- word_valid  in  1  word_in valid
- word_ready  out  1  unpacker accepts word_in this cycle
- coeff_out  out  COEFF_W  current coefficient
- coeff_valid  out  1  coeff_out valid
- coeff_ready  in  1  downstream accepts coeff_out
- busy  out  1  polynomial in progress
- done  out  1  one-cycle pulse after last coefficient handshake

## Operation
Bit order:
- The stream is the concatenation of words, word 0 first, LSB first.
- Coefficient i occupies stream bits [i*w +: w], where w = SHORT_W or COEFF_W per the latched mode.
- Words fetched = ceil(N_COEFF*w/WORD_W); trailing pad bits of the last word are discarded.

Buffer:
- BUF_W = 2*WORD_W bits, with a fill counter 0..BUF_W.
- Word handshake (word_valid && word_ready): the word is written at bit position fill (after any same-cycle shift); fill += WORD_W.
- Coefficient handshake (coeff_valid && coeff_ready): buffer shifts right by w; fill -= w.
- Simultaneous word and coefficient handshakes are legal. Net fill = fill - w + WORD_W, and the new word lands at position fill - w.
- word_ready = busy && words_left != 0 && (fill + WORD_W <= BUF_W, evaluated with any same-cycle coefficient handshake counted, i.e. fill - w + WORD_W <= BUF_W when emitting).
- coeff_out = buffer[w-1:0], zero-extended to COEFF_W in short mode (see Configuration).
- coeff_valid = (state == RUN) && fill >= w && coeffs_left != 0.

State machine:
- IDLE:
  - start -> RUN.
  - On entry to RUN: latch mode, fill = 0, words_left = word count, coeffs_left = N_COEFF.
  - Other inputs are ignored.
- RUN:
  - On the last coefficient handshake (coeffs_left 1 -> 0) -> DONE.
  - start is ignored.
- DONE:
  - done = 1 for one cycle, then -> IDLE.
  - Residual pad bits are cleared: fill = 0.

busy = (state != IDLE).

## Timing
- Reset: state IDLE, fill 0, buffer 0, coeff_out 0, coeff_valid 0, word_ready 0, busy 0, done 0.
- Reset asserted mid-polynomial aborts immediately with no done pulse.
- word_ready may assert in the cycle after start.
- Latency: a coefficient completed by a word accepted at edge k has coeff_valid high in the cycle after edge k.
- Throughput: one coefficient per cycle sustained when word_valid and coeff_ready are held high.
- coeff_out and coeff_valid hold stable while coeff_valid && !coeff_ready.
- done is asserted in the cycle after the final coefficient handshake; busy deasserts one cycle later.
- start arriving in the DONE cycle is ignored.

## Configuration
- COEFF_UNPACKER_SEXT_EN defined: short-mode coefficients are sign-extended from bit SHORT_W-1 to COEFF_W.
- Not defined: short-mode coefficients are zero-extended.
- Full mode is unaffected either way.

## Test plan
- 13-bit mode, defaults: stream a ramp with coefficient i = i. The block fetches exactly 52 words and emits 0, 1, ..., 255 in order. done pulses once; busy falls on the following cycle.
- 10-bit mode: 40 all-ones words. Emits 256 × 0x03FF without the macro, 256 × 0x1FFF with COEFF_UNPACKER_SEXT_EN. Exactly 40 word handshakes.
- Backpressure:
  - Random coeff_ready (50%) and random word_valid gaps during the ramp.
  - Output sequence is unchanged.
  - coeff_out stays stable while stalled.
  - Fill never exceeds 128; word_ready is low whenever the buffer is full.
- Full rate: word_valid and coeff_ready held high in 13-bit mode. 256 coefficients arrive in ≤ 258 cycles after the first word accept.
- start pulsed while busy and in the DONE cycle: ignored, so the count and mode stay unchanged. A fresh start in IDLE with the opposite mode decodes correctly.
- rst_n low after 100 coefficients: all outputs go to their reset values asynchronously with no done pulse. A subsequent start and stream produce the full 0..255 sequence.
